control_loop_sequencer: RTL and testbench

//  Initiator side of the control-loop arm/finished handshake. Runs the loop:
//  ADC sample -> arm the loop math -> capture e_cur/adj_val -> write DAC.

---
 rtl/control_loop_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_loop_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_loop_sequencer.sv
// Initiator side of the control-loop arm/finished handshake: ADC sample -> loop math -> DAC write.
// Keeps the inter-sample cycle count and error/adjust history and saturates adj_val to the DAC.
module control_loop_sequencer #(
    parameter int unsigned CONSTS_WHOLE    = 21,
    parameter int unsigned CONSTS_FRAC     = 43,
    parameter int unsigned ADC_WID         = 18,
    parameter int unsigned DAC_WID         = 20,
    parameter int unsigned CYCLE_COUNT_WID = 18
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_run,
    input  logic [ADC_WID-1:0]                  i_setpt,
    input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] i_cl_p,
    input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] i_cl_i,
    output logic                                o_adc_arm,
    input  logic                                i_adc_fin,
    input  logic [ADC_WID-1:0]                  i_adc_data,
    output logic                                o_math_arm,
    input  logic                                i_math_finished,
    output logic [ADC_WID-1:0]                  o_math_setpt,
    output logic [ADC_WID-1:0]                  o_math_measured,
    output logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] o_math_cl_p,
    output logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] o_math_cl_i,
    output logic [CYCLE_COUNT_WID-1:0]          o_math_cycles,
    output logic [ADC_WID:0]                    o_math_e_prev,
    output logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] o_math_adjval_prev,
    input  logic [ADC_WID:0]                    i_math_e_cur,
    input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] i_math_adj_val,
    output logic                                o_dac_arm,
    input  logic                                i_dac_fin,
    output logic [DAC_WID-1:0]                  o_dac_data,
    output logic                                o_busy,
    output logic [31:0]                         o_iter_count
);

    localparam int unsigned CW    = CONSTS_WHOLE + CONSTS_FRAC;
    localparam int unsigned E_WID = ADC_WID + 1;
    localparam int DacMaxInt = (1 << (DAC_WID - 1)) - 1;
    localparam logic signed [CONSTS_WHOLE-1:0] WholeMax = CONSTS_WHOLE'(DacMaxInt);
    localparam logic signed [CONSTS_WHOLE-1:0] WholeMin = CONSTS_WHOLE'(-DacMaxInt - 1);
    localparam logic [DAC_WID-1:0] DacMax = {1'b0, {(DAC_WID - 1){1'b1}}};
    localparam logic [DAC_WID-1:0] DacMin = {1'b1, {(DAC_WID - 1){1'b0}}};
    localparam logic [CYCLE_COUNT_WID-1:0] CntMax = {1'b0, {(CYCLE_COUNT_WID - 1){1'b1}}};

    typedef enum logic [2:0] {
        StIdle, StAdcWait, StAdcRel, StMathWait, StMathRel, StDacWait, StDacRel
    } state_e;

    state_e                     r_state, w_state_nxt;
    logic                       r_adc_arm, w_adc_arm_nxt;
    logic                       r_math_arm, w_math_arm_nxt;
    logic                       r_dac_arm, w_dac_arm_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_first, w_first_nxt;
    logic [ADC_WID-1:0]         r_setpt, w_setpt_nxt;
    logic [ADC_WID-1:0]         r_measured, w_measured_nxt;
    logic [CW-1:0]              r_cl_p, w_cl_p_nxt;
    logic [CW-1:0]              r_cl_i, w_cl_i_nxt;
    logic [CYCLE_COUNT_WID-1:0] r_cycles, w_cycles_nxt;
    logic [CYCLE_COUNT_WID-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [E_WID-1:0]           r_e_prev, w_e_prev_nxt;
    logic [CW-1:0]              r_adjval_prev, w_adjval_prev_nxt;
    logic [DAC_WID-1:0]         r_dac_data, w_dac_data_nxt, w_dac_sat;
    logic [31:0]                r_iter, w_iter_nxt;
    logic signed [CONSTS_WHOLE-1:0] w_whole;

    // Whole part by truncation of the fraction, i.e. floor for negative values.
    assign w_whole   = i_math_adj_val[CW-1:CONSTS_FRAC];
    assign w_dac_sat = (w_whole > WholeMax) ? DacMax :
                       (w_whole < WholeMin) ? DacMin : w_whole[DAC_WID-1:0];
    assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CYCLE_COUNT_WID'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_adc_arm_nxt     = r_adc_arm;
        w_math_arm_nxt    = r_math_arm;
        w_dac_arm_nxt     = r_dac_arm;
        w_first_nxt       = r_first;
        w_setpt_nxt       = r_setpt;
        w_measured_nxt    = r_measured;
        w_cl_p_nxt        = r_cl_p;
        w_cl_i_nxt        = r_cl_i;
        w_cycles_nxt      = r_cycles;
        w_cnt_nxt         = w_cnt_inc;
        w_e_prev_nxt      = r_e_prev;
        w_adjval_prev_nxt = r_adjval_prev;
        w_dac_data_nxt    = r_dac_data;
        w_iter_nxt        = r_iter;
        unique case (r_state)
            StIdle: begin
                w_cnt_nxt         = '0;
                w_e_prev_nxt      = '0;
                w_adjval_prev_nxt = '0;
                w_first_nxt       = 1'b1;
                if (i_run) begin
                    w_adc_arm_nxt = 1'b1;
                    w_state_nxt   = StAdcWait;
                end
            end
            StAdcWait: if (i_adc_fin) begin
                w_measured_nxt = i_adc_data;
                w_setpt_nxt    = i_setpt;
                w_cl_p_nxt     = i_cl_p;
                w_cl_i_nxt     = i_cl_i;
                // No previous sample since IDLE, so there is no interval to report.
                w_cycles_nxt   = r_first ? '0 : w_cnt_inc;
                w_cnt_nxt      = '0;
                w_first_nxt    = 1'b0;
                w_adc_arm_nxt  = 1'b0;
                w_state_nxt    = StAdcRel;
            end
            StAdcRel: if (!i_adc_fin) begin
                w_math_arm_nxt = 1'b1;
                w_state_nxt    = StMathWait;
            end
            StMathWait: if (i_math_finished) begin
                w_e_prev_nxt      = i_math_e_cur;
                w_adjval_prev_nxt = i_math_adj_val;
                w_dac_data_nxt    = w_dac_sat;
                w_math_arm_nxt    = 1'b0;
                w_state_nxt       = StMathRel;
            end
            StMathRel: if (!i_math_finished) begin
                w_dac_arm_nxt = 1'b1;
                w_state_nxt   = StDacWait;
            end
            StDacWait: if (i_dac_fin) begin
                w_dac_arm_nxt = 1'b0;
                w_iter_nxt    = r_iter + 32'd1;
                w_state_nxt   = StDacRel;
            end
            StDacRel: if (!i_dac_fin) begin
                if (i_run) begin
                    w_adc_arm_nxt = 1'b1;
                    w_state_nxt   = StAdcWait;
                end else begin
                    w_state_nxt   = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_adc_arm     <= 1'b0;
            r_math_arm    <= 1'b0;
            r_dac_arm     <= 1'b0;
            r_busy        <= 1'b0;
            r_first       <= 1'b1;
            r_setpt       <= '0;
            r_measured    <= '0;
            r_cl_p        <= '0;
            r_cl_i        <= '0;
            r_cycles      <= '0;
            r_cnt         <= '0;
            r_e_prev      <= '0;
            r_adjval_prev <= '0;
            r_dac_data    <= '0;
            r_iter        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_adc_arm     <= w_adc_arm_nxt;
            r_math_arm    <= w_math_arm_nxt;
            r_dac_arm     <= w_dac_arm_nxt;
            r_busy        <= w_busy_nxt;
            r_first       <= w_first_nxt;
            r_setpt       <= w_setpt_nxt;
            r_measured    <= w_measured_nxt;
            r_cl_p        <= w_cl_p_nxt;
            r_cl_i        <= w_cl_i_nxt;
            r_cycles      <= w_cycles_nxt;
            r_cnt         <= w_cnt_nxt;
            r_e_prev      <= w_e_prev_nxt;
            r_adjval_prev <= w_adjval_prev_nxt;
            r_dac_data    <= w_dac_data_nxt;
            r_iter        <= w_iter_nxt;
        end
    end

    assign o_adc_arm          = r_adc_arm;
    assign o_math_arm         = r_math_arm;
    assign o_dac_arm          = r_dac_arm;
    assign o_busy             = r_busy;
    assign o_math_setpt       = r_setpt;
    assign o_math_measured    = r_measured;
    assign o_math_cl_p        = r_cl_p;
    assign o_math_cl_i        = r_cl_i;
    assign o_math_cycles      = r_cycles;
    assign o_math_e_prev      = r_e_prev;
    assign o_math_adjval_prev = r_adjval_prev;
    assign o_dac_data         = r_dac_data;
    assign o_iter_count       = r_iter;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Directed bench for control_loop_sequencer: ADC/math/DAC peers driven from one initial block,
// expected outputs queued at stimulus time and compared when the DUT presents them.
module tb_control_loop_sequencer;

    localparam int unsigned CWH = 21;
    localparam int unsigned CFR = 43;
    localparam int unsigned AW  = 18;
    localparam int unsigned DW  = 20;
    // Narrow cycle counter so saturation is reachable in a short run.
    localparam int unsigned CCW = 12;
    localparam int unsigned CW  = CWH + CFR;
    localparam int unsigned EW  = AW + 1;
    localparam int CYC_MAX = (1 << (CCW - 1)) - 1;
    localparam int BUDGET  = 200;

    logic           clk, rst, run;
    logic [AW-1:0]  setpt, adc_data, math_setpt, math_measured;
    logic [CW-1:0]  cl_p, cl_i, math_cl_p, math_cl_i, math_adjval_prev, math_adj_val;
    logic           adc_arm, adc_fin, math_arm, math_finished, dac_arm, dac_fin, busy;
    logic [CCW-1:0] math_cycles;
    logic [EW-1:0]  math_e_prev, math_e_cur;
    logic [DW-1:0]  dac_data;
    logic [31:0]    iter_count;

    control_loop_sequencer #(
        .CONSTS_WHOLE(CWH), .CONSTS_FRAC(CFR), .ADC_WID(AW), .DAC_WID(DW), .CYCLE_COUNT_WID(CCW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_setpt(setpt), .i_cl_p(cl_p), .i_cl_i(cl_i),
        .o_adc_arm(adc_arm), .i_adc_fin(adc_fin), .i_adc_data(adc_data),
        .o_math_arm(math_arm), .i_math_finished(math_finished),
        .o_math_setpt(math_setpt), .o_math_measured(math_measured),
        .o_math_cl_p(math_cl_p), .o_math_cl_i(math_cl_i), .o_math_cycles(math_cycles),
        .o_math_e_prev(math_e_prev), .o_math_adjval_prev(math_adjval_prev),
        .i_math_e_cur(math_e_cur), .i_math_adj_val(math_adj_val),
        .o_dac_arm(dac_arm), .i_dac_fin(dac_fin), .o_dac_data(dac_data),
        .o_busy(busy), .o_iter_count(iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;
    int prev_cap = 0;
    bit m_first = 1'b1;
    logic [EW-1:0] m_e_prev   = '0;
    logic [CW-1:0] m_adj_prev = '0;
    logic [31:0]   m_iter     = '0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    function automatic logic [63:0] obs(input string tag);
        if (tag == "adc_arm")          return 64'(adc_arm);
        if (tag == "math_arm")         return 64'(math_arm);
        if (tag == "dac_arm")          return 64'(dac_arm);
        if (tag == "busy")             return 64'(busy);
        if (tag == "dac_data")         return 64'(dac_data);
        if (tag == "iter_count")       return 64'(iter_count);
        if (tag == "math_cycles")      return 64'(math_cycles);
        if (tag == "math_e_prev")      return 64'(math_e_prev);
        if (tag == "math_adjval_prev") return 64'(math_adjval_prev);
        if (tag == "math_measured")    return 64'(math_measured);
        if (tag == "math_setpt")       return 64'(math_setpt);
        if (tag == "math_cl_p")        return 64'(math_cl_p);
        if (tag == "math_cl_i")        return 64'(math_cl_i);
        return 64'bx;
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.tag), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait; an expired bound shows up as a failed comparison of the signal level.
    task automatic wait_level(input string which, input logic level);
        logic [63:0] v;
        int n = 0;
        v = obs(which);
        while (v[0] !== level && n < BUDGET) begin
            step();
            n++;
            v = obs(which);
        end
        check({which, "_wait"}, v, 64'(level));
    endtask

    task automatic do_iter(input logic [AW-1:0] sp, input logic [AW-1:0] adc,
                           input logic [EW-1:0] ecur, input logic [CW-1:0] adj,
                           input logic [DW-1:0] exp_dac, input int gap, input int hold,
                           input bit drop_run);
        logic [CW-1:0] pv, iv;
        int cap, exp_cyc, n;
        wait_level("adc_arm", 1'b1);
        if (gap > 0) begin
            n = 0;
            while (cyc < prev_cap + gap - 1 && n < gap + BUDGET) begin
                step();
                n++;
            end
        end
        pv = {$urandom, $urandom};
        iv = {$urandom, $urandom};
        setpt = sp; cl_p = pv; cl_i = iv; adc_data = adc; adc_fin = 1'b1;
        cap = cyc + 1;
        exp_cyc = m_first ? 0 : ((cap - prev_cap) > CYC_MAX ? CYC_MAX : cap - prev_cap);
        push("math_measured", 64'(adc));
        push("math_setpt", 64'(sp));
        push("math_cl_p", 64'(pv));
        push("math_cl_i", 64'(iv));
        push("math_cycles", 64'(exp_cyc));
        push("math_e_prev", 64'(m_e_prev));
        push("math_adjval_prev", 64'(m_adj_prev));
        wait_level("adc_arm", 1'b0);
        // Post-capture input changes must not reach the snapshot.
        setpt = ~sp; cl_p = ~pv; cl_i = ~iv; adc_data = ~adc;
        prev_cap = cap;
        m_first = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check("math_arm_held", 64'(math_arm), 64'd0);
        end
        adc_fin = 1'b0;
        step();
        check("math_arm_latency", 64'(math_arm), 64'd1);
        drain();
        math_e_cur = ecur; math_adj_val = adj; math_finished = 1'b1;
        push("dac_data", 64'(exp_dac));
        m_e_prev = ecur;
        m_adj_prev = adj;
        wait_level("math_arm", 1'b0);
        math_finished = 1'b0; math_e_cur = ~ecur; math_adj_val = ~adj;
        step();
        check("dac_arm_latency", 64'(dac_arm), 64'd1);
        drain();
        if (drop_run) run = 1'b0;
        dac_fin = 1'b1;
        m_iter++;
        push("iter_count", 64'(m_iter));
        wait_level("dac_arm", 1'b0);
        drain();
        dac_fin = 1'b0;
        if (drop_run) begin
            m_first = 1'b1;
            m_e_prev = '0;
            m_adj_prev = '0;
        end
    endtask

    string rst_names [13] = '{"adc_arm", "math_arm", "dac_arm", "busy", "dac_data", "iter_count",
        "math_cycles", "math_e_prev", "math_adjval_prev", "math_measured", "math_setpt",
        "math_cl_p", "math_cl_i"};

    initial begin
        logic seen;
        rst = 1'b1; run = 1'b0; setpt = '0; cl_p = '0; cl_i = '0; adc_fin = 1'b0;
        adc_data = '0; math_finished = 1'b0; math_e_cur = '0; math_adj_val = '0;
        dac_fin = 1'b0;
        repeat (3) step();
        foreach (rst_names[i]) check({"rst_", rst_names[i]}, obs(rst_names[i]), 64'd0);
        rst = 1'b0;
        step();
        run = 1'b1;

        // 5.25 -> 5, then positive/negative saturation edges, interval and stall counts.
        do_iter(18'd100, 18'd40, 19'd60, 64'h0000_2A00_0000_0000, 20'h00005, 0, 0, 1'b0);
        do_iter(18'd100, 18'h3FFF0, 19'd116, 64'h7FFF_F800_0000_0000, 20'h7FFFF, 0, 0, 1'b0);
        do_iter(18'd7, 18'd3, 19'd4, 64'h4000_0000_0000_0000, 20'h7FFFF, 1000, 0, 1'b0);
        do_iter(18'd9, 18'd8, 19'd1, 64'h3FFF_F800_0000_0000, 20'h7FFFF, 0, 0, 1'b0);
        do_iter(18'd1, 18'd2, 19'h7FFFF, 64'h8000_0000_0000_0000, 20'h80000, 5000, 0, 1'b0);
        do_iter(18'd5, 18'd6, 19'h7FFFF, 64'hBFFF_F800_0000_0000, 20'h80000, 0, 5, 1'b0);
        do_iter(18'd5, 18'd6, 19'h7FFFF, 64'hC000_0000_0000_0000, 20'h80000, 0, 0, 1'b0);
        do_iter(18'd3, 18'd3, 19'd0, 64'hFFFF_FC00_0000_0000, 20'hFFFFF, 0, 0, 1'b1);

        seen = 1'b0;
        repeat (30) begin
            step();
            seen = seen | adc_arm;
        end
        check("idle_no_adc_arm", 64'(seen), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Restart: first sample after IDLE reports 0 cycles and cleared history.
        run = 1'b1;
        do_iter(18'd5, 18'd7, 19'h7FFFE, 64'hFFFF_E800_0000_0000, 20'hFFFFD, 0, 0, 1'b0);

        // Abandon an iteration in MATH_WAIT with an asynchronous reset.
        wait_level("adc_arm", 1'b1);
        adc_data = 18'd11; adc_fin = 1'b1;
        wait_level("adc_arm", 1'b0);
        adc_fin = 1'b0;
        wait_level("math_arm", 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_adc_arm", 64'(adc_arm), 64'd0);
        check("arst_math_arm", 64'(math_arm), 64'd0);
        check("arst_dac_arm", 64'(dac_arm), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_dac_data", 64'(dac_data), 64'd0);
        check("arst_iter_count", 64'(iter_count), 64'd0);
        check("arst_math_e_prev", 64'(math_e_prev), 64'd0);
        run = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_adc_arm", 64'(adc_arm), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
